// File: rtl/instr_encoder.sv
// RV32I field packer: encodes one field bundle per cycle into a 32-bit
// instruction word and streams it into the instruction memory write port.
module instr_encoder #(
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic              err_sticky,
    output logic              done
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       enc_word;
    logic              imm_ok;
    logic              accept;
    logic              fits_12;
    logic              fits_13_even;
    logic              fits_21_even;

    // An immediate fits N signed bits when every bit above N-2 matches the sign.
    assign fits_12      = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13_even = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
    assign fits_21_even = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];

    assign in_ready = !done && !clear && (word_count < DEPTH_W);
    assign accept   = in_valid && in_ready;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and infers a latch.
    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
                imm_ok   = 1'b1;
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                imm_ok   = fits_12;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_ok   = fits_12;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
                imm_ok   = fits_13_even;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                imm_ok   = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                imm_ok   = fits_21_even;
            end
            default: begin
                enc_word = '0;
                imm_ok   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= BASE_ADDR;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            done       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            err     <= 1'b0;
            if (clear) begin
                wr_addr    <= BASE_ADDR;
                imem_addr  <= '0;
                imem_wdata <= '0;
                word_count <= '0;
                err_sticky <= 1'b0;
                done       <= 1'b0;
            end else if (accept) begin
                if (imm_ok) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= wr_addr;
                    imem_wdata <= enc_word;
                    wr_addr    <= wr_addr + 1'b1;
                    word_count <= word_count + 1'b1;
                end else begin
                    err        <= 1'b1;
                    err_sticky <= 1'b1;
                end
                // done rises with the write so no further bundle slips in behind it.
                if (in_last || (imm_ok && (word_count == DEPTH_W - 1'b1)))
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a field-arithmetic reference model.
module tb_instr_encoder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int BASE   = 0;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              err;
    logic              err_sticky;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int  m_count;
    bit  m_done;
    bit  m_sticky;

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(ADDR_W'(BASE))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .word_count(word_count),
        .err       (err),
        .err_sticky(err_sticky),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] u, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (u >> lo) & mask;
    endfunction

    function automatic bit ref_ok(input logic [2:0] f, input logic [31:0] u);
        int si;
        si = $signed(u);
        case (f)
            3'd0:    return 1'b1;
            3'd1,
            3'd2:    return (si >= -2048) && (si <= 2047);
            3'd3:    return (si >= -4096) && (si <= 4094) && (u[0] == 1'b0);
            3'd4:    return (u & 32'h0000_0FFF) == 32'd0;
            3'd5:    return (si >= -1048576) && (si <= 1048574) && (u[0] == 1'b0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
                                            input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] u);
        logic [31:0] base;
        base = 32'(op) | (32'(f3) << 12);
        case (f)
            3'd0: return base | (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(d) << 7);
            3'd1: return base | (fld(u, 11, 0) << 20) | (32'(s1) << 15) | (32'(d) << 7);
            3'd2: return base | (fld(u, 11, 5) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                              | (fld(u, 4, 0) << 7);
            3'd3: return base | (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (32'(s2) << 20)
                              | (32'(s1) << 15) | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7);
            3'd4: return 32'(op) | (u & 32'hFFFF_F000) | (32'(d) << 7);
            default: return 32'(op) | (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21)
                              | (fld(u, 11, 11) << 20) | (fld(u, 19, 12) << 12) | (32'(d) << 7);
        endcase
    endfunction

    // One clock of stimulus; the model predicts and the DUT is compared after the edge.
    task automatic drive(input bit v, input bit last, input bit clr,
                         input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] u);
        bit          m_ready, acc, good, exp_we, exp_err;
        logic [31:0] exp_data;
        int          exp_addr;
        in_valid = v;  in_last = last;  clear = clr;
        fmt = f;  opcode = op;  rd = d;  rs1 = s1;  rs2 = s2;
        funct3 = f3;  funct7 = f7;  imm = u;
        #1;
        m_ready = !m_done && !clr && (m_count < DEPTH);
        check("in_ready", 32'(in_ready), 32'(m_ready));
        acc      = v && m_ready;
        good     = ref_ok(f, u);
        exp_data = ref_enc(f, op, d, s1, s2, f3, f7, u);
        exp_addr = BASE + m_count;
        @(posedge clk);
        #1;
        exp_we  = 1'b0;
        exp_err = 1'b0;
        if (clr) begin
            m_count  = 0;
            m_done   = 1'b0;
            m_sticky = 1'b0;
        end else if (acc) begin
            if (good) begin
                exp_we = 1'b1;
                m_count++;
                if (m_count == DEPTH) m_done = 1'b1;
            end else begin
                exp_err  = 1'b1;
                m_sticky = 1'b1;
            end
            if (last) m_done = 1'b1;
        end
        check("imem_we", 32'(imem_we), 32'(exp_we));
        check("err", 32'(err), 32'(exp_err));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("word_count", 32'(word_count), 32'(m_count));
        check("done", 32'(done), 32'(m_done));
        if (exp_we) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            check("imem_wdata", imem_wdata, exp_data);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    endtask

    task automatic do_clear();
        drive(1, 0, 1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    endtask

    int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 32'h1000, 32'h1001};

    initial begin
        rst_n = 1'b0;  clear = 1'b0;  in_valid = 1'b0;  in_last = 1'b0;
        fmt = '0;  opcode = '0;  rd = '0;  rs1 = '0;  rs2 = '0;
        funct3 = '0;  funct7 = '0;  imm = '0;
        m_count = 0;  m_done = 1'b0;  m_sticky = 1'b0;

        // Reset state
        #12;
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err) | 32'(err_sticky), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // R-type
        drive(1, 0, 0, 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("r_data", imem_wdata, 32'h002081B3);
        check("r_addr", 32'(imem_addr), 32'd0);
        check("r_count", 32'(word_count), 32'd1);
        do_clear();

        // I, S, B, J back to back fill the memory
        drive(1, 0, 0, 3'd1, 7'b0000011, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd4);
        check("i_data", imem_wdata, 32'h0040A103);
        drive(1, 0, 0, 3'd2, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd4);
        check("s_data", imem_wdata, 32'h00312223);
        check("s_addr", 32'(imem_addr), 32'd1);
        drive(1, 0, 0, 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
        check("b_data", imem_wdata, 32'hFE208EE3);
        drive(1, 0, 0, 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd8);
        check("j_data", imem_wdata, 32'hFF9FF0EF);
        check("full_done", 32'(done), 32'd1);
        drive(1, 0, 0, 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("full_no_we", 32'(imem_we), 32'd0);
        do_clear();

        // Rejects followed by a good U
        drive(1, 0, 0, 3'd1, 7'b0000011, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd2048);
        check("rej_i_err", 32'(err), 32'd1);
        drive(1, 0, 0, 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        drive(1, 0, 0, 3'd4, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001);
        check("rej_u_sticky", 32'(err_sticky), 32'd1);
        drive(1, 0, 0, 3'd4, 7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000);
        check("u_data", imem_wdata, 32'h00001037);
        check("u_addr", 32'(imem_addr), 32'd0);
        do_clear();

        // in_last on the second bundle
        drive(1, 0, 0, 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        drive(1, 1, 0, 3'd0, 7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        check("last_done", 32'(done), 32'd1);
        check("last_count", 32'(word_count), 32'd2);
        drive(1, 0, 0, 3'd0, 7'b0110011, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        do_clear();
        idle();
        check("clr_count", 32'(word_count), 32'd0);
        check("clr_ready", 32'(in_ready), 32'd1);

        // Async reset while a write is in flight
        in_valid = 1'b1;  clear = 1'b0;  in_last = 1'b0;
        fmt = 3'd0;  opcode = 7'b0110011;  rd = 5'd7;  rs1 = 5'd1;  rs2 = 5'd2;
        @(posedge clk);
        #1;
        check("flight_we", 32'(imem_we), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_we", 32'(imem_we), 32'd0);
        check("arst_count", 32'(word_count), 32'd0);
        m_count = 0;  m_done = 1'b0;  m_sticky = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 3'd1, 7'b0010011, 5'd9, 5'd3, 5'd0, 3'd0, 7'd0, 32'd100);
        check("arst_addr", 32'(imem_addr), 32'(BASE));

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            logic [31:0] u;
            if (m_done) begin
                do_clear();
                continue;
            end
            case ($urandom_range(0, 5))
                0: u = 32'($urandom_range(0, 64)) - 32'd32;
                1: u = $urandom;
                2: u = bnd[$urandom_range(0, 14)];
                3: u = (32'($urandom_range(0, 8000)) - 32'd4000) & ~32'd1;
                4: u = $urandom & 32'hFFFF_F000;
                default: u = (32'($urandom_range(0, 2000000)) - 32'd1000000) & ~32'd1;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0,
                  3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), u);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
